// File: rtl/sw_reg_wr.sv
// Wishbone B3 classic slave: a single byte-writable register driven to the fabric.
// Define SW_REG_WR_INT_EN to get a one-cycle wbs_int_o pulse after each non-empty write.

module sw_reg_wr_lane (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       wr_en,
  input  logic [7:0] din,
  output logic [7:0] q
);

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i)  q <= '0;
    else if (wr_en) q <= din;
  end

endmodule

module sw_reg_wr #(
  parameter logic [31:0] DEV_BASE_ADDR  = 32'h0,
  parameter logic [31:0] DEV_HIGH_ADDR  = 32'h0F,
  parameter int          BUS_DATA_WIDTH = 32,
  parameter int          BUS_ADDR_WIDTH = 8
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        wbs_cyc_i,
  input  logic                        wbs_stb_i,
  input  logic                        wbs_we_i,
  input  logic [BUS_DATA_WIDTH/8-1:0] wbs_sel_i,
  input  logic [BUS_ADDR_WIDTH-1:0]   wbs_adr_i,
  input  logic [BUS_DATA_WIDTH-1:0]   wbs_dat_i,
  output logic [BUS_DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                        wbs_ack_o,
  output logic                        wbs_int_o,
  output logic [BUS_DATA_WIDTH-1:0]   fabric_data_o
);

  localparam int NUM_LANES = BUS_DATA_WIDTH / 8;

  typedef struct packed {
    logic                          cyc;
    logic                          stb;
    logic                          we;
    logic [NUM_LANES-1:0]          sel;
    logic [BUS_ADDR_WIDTH-1:0]     adr;
    logic [NUM_LANES-1:0][7:0]     dat;
  } wb_req_t;

  wb_req_t                   req;
  logic [NUM_LANES-1:0][7:0] reg_q;
  logic [31:0]               adr_ext;
  logic [32:0]               diff_lo, diff_hi;
  logic                      hit, req_vld, wr_acc;

  assign req = '{cyc: wbs_cyc_i, stb: wbs_stb_i, we: wbs_we_i,
                 sel: wbs_sel_i, adr: wbs_adr_i, dat: wbs_dat_i};

  // Window check via 33-bit borrow so a zero base never folds to a constant compare.
  assign adr_ext = 32'(req.adr);
  assign diff_lo = {1'b0, adr_ext} - {1'b0, DEV_BASE_ADDR};
  assign diff_hi = {1'b0, DEV_HIGH_ADDR} - {1'b0, adr_ext};
  assign hit     = ~diff_lo[32] & ~diff_hi[32];

  assign req_vld = req.cyc & req.stb & hit;
  assign wr_acc  = req_vld & req.we & ~wbs_ack_o;

  // Ack toggles under a held request, so every second cycle completes a transfer.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) wbs_ack_o <= 1'b0;
    else           wbs_ack_o <= req_vld & ~wbs_ack_o;
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    sw_reg_wr_lane u_lane (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .wr_en    (wr_acc & req.sel[g]),
      .din      (req.dat[g]),
      .q        (reg_q[g])
    );
  end

  assign wbs_dat_o     = reg_q;
  assign fabric_data_o = reg_q;

`ifdef SW_REG_WR_INT_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) wbs_int_o <= 1'b0;
    else           wbs_int_o <= wr_acc & (|req.sel);
  end
`else
  assign wbs_int_o = 1'b0;
`endif

endmodule

// File: tb/tb_sw_reg_wr.sv
// Directed bench for sw_reg_wr: byte enables, aliasing, window edges, ack toggling, reset.

module tb_sw_reg_wr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [7:0]  adr = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o, fab;
  logic        ack, irq;

  int checks = 0;
  int errors = 0;

  sw_reg_wr #(
    .DEV_BASE_ADDR (32'h0),
    .DEV_HIGH_ADDR (32'h0F),
    .BUS_DATA_WIDTH(32),
    .BUS_ADDR_WIDTH(8)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst_n),
    .wbs_cyc_i    (cyc),
    .wbs_stb_i    (stb),
    .wbs_we_i     (we),
    .wbs_sel_i    (sel),
    .wbs_adr_i    (adr),
    .wbs_dat_i    (dat_i),
    .wbs_dat_o    (dat_o),
    .wbs_ack_o    (ack),
    .wbs_int_o    (irq),
    .fabric_data_o(fab)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

`ifdef SW_REG_WR_INT_EN
  localparam logic INT_ON = 1'b1;
`else
  localparam logic INT_ON = 1'b0;
`endif

  // One single transfer: request for one edge, check ack/data, release, check ack drop.
  task automatic xfer(input string tag, input logic w, input logic [7:0] a,
                      input logic [3:0] s, input logic [31:0] d,
                      input logic [31:0] exp_reg, input logic exp_int);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d;
    #1 check({tag, "_ack_pre"}, ack, 1'b0);
    @(negedge clk);
    check({tag, "_ack"}, ack, 1'b1);
    check({tag, "_dat"}, dat_o, exp_reg);
    check({tag, "_fab"}, fab, exp_reg);
    check({tag, "_int"}, irq, exp_int & INT_ON);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    check({tag, "_ack_end"}, ack, 1'b0);
    check({tag, "_int_end"}, irq, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ack", ack, 1'b0);
    check("rst_dat", dat_o, 32'h0);
    check("rst_fab", fab, 32'h0);
    check("rst_int", irq, 1'b0);
    rst_n = 1'b1;

    xfer("wr_selA",  1'b1, 8'h00, 4'hA, 32'hEEEEEEEE, 32'hEE00EE00, 1'b1);
    xfer("rd_00",    1'b0, 8'h00, 4'hF, 32'h0,        32'hEE00EE00, 1'b0);
    xfer("wr_sel1",  1'b1, 8'h04, 4'h1, 32'h12345678, 32'hEE00EE78, 1'b1);
    xfer("wr_full",  1'b1, 8'h0F, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
    xfer("rd_alias", 1'b0, 8'h07, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0);
    xfer("wr_sel0",  1'b1, 8'h03, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0);

    // Out of window: just above the high address.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h10; sel = 4'hF; dat_i = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("oow_ack%0d", i), ack, 1'b0);
      check($sformatf("oow_int%0d", i), irq, 1'b0);
    end
    check("oow_dat", dat_o, 32'hDEADBEEF);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;

    // cyc low with stb high never starts a transfer.
    @(negedge clk);
    cyc = 1'b0; stb = 1'b1; we = 1'b1; adr = 8'h00; sel = 4'hF; dat_i = 32'h0;
    repeat (2) @(negedge clk);
    check("nocyc_ack", ack, 1'b0);
    check("nocyc_dat", dat_o, 32'hDEADBEEF);
    stb = 1'b0; we = 1'b0;

    // Held write strobe: ack and interrupt toggle 0,1,0,1.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h08; sel = 4'h1; dat_i = 32'h000000A5;
    #1;
    check("hold_ack0", ack, 1'b0);
    check("hold_int0", irq, 1'b0);
    @(negedge clk); check("hold_ack1", ack, 1'b1); check("hold_int1", irq, INT_ON);
    @(negedge clk); check("hold_ack2", ack, 1'b0); check("hold_int2", irq, 1'b0);
    @(negedge clk); check("hold_ack3", ack, 1'b1); check("hold_int3", irq, INT_ON);
    check("hold_dat", dat_o, 32'hDEADBEA5);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    check("hold_ack_end", ack, 1'b0);

    // Reset in the middle of a transfer clears ack and register asynchronously.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h00;
    @(negedge clk);
    check("mid_ack", ack, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ack", ack, 1'b0);
    check("mid_rst_dat", dat_o, 32'h0);
    check("mid_rst_fab", fab, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer("wr_post", 1'b1, 8'h0C, 4'h6, 32'h11223344, 32'h00223300, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
